adder_rr_sched: RTL

- Round-robin scheduler that shares one `adder` instance (WIDTH-bit a/b in, WIDTH+1-bit registered q out) among NUM_REQ requesters.
- Accepts operand pairs over a per-requester valid/ready handshake, issues at most one pair per cycle to the adder, and tracks in-flight operations through the adder latency.
- Returns each sum tagged with the requester index.
- Sits between requester blocks and the adder in the arithmetic subsystem.

---
 rtl/adder_rr_sched_if.sv | 27 ++
 rtl/adder_rr_sched.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/adder_rr_sched_if.sv
// adder_rr_sched_if: requester-side bus of the round-robin adder scheduler.
// Carries the per-requester operand handshake and the tagged result stream.
// master = requester cluster, slave = scheduler.
interface adder_rr_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     resp_valid;
  logic [ID_W-1:0]          resp_id;
  logic [WIDTH:0]           resp_q;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, resp_valid, resp_id, resp_q
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, resp_valid, resp_id, resp_q
  );
endinterface

// File: rtl/adder_rr_sched.sv
// adder_rr_sched: shares one registered adder among NUM_REQ requesters.
// A round-robin arbiter picks at most one operand pair per cycle, registers it
// onto the adder inputs, and a {valid,id} shift register follows the operation
// through the adder so the sum comes back tagged with its requester index.
// Defining ADDER_RR_SCHED_STATS_EN adds saturating stat_issued / stat_stall
// counters; without it those ports do not exist.
module adder_rr_sched #(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 8,
  parameter int ADD_LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  adder_rr_sched_if.slave    bus,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  input  logic [WIDTH:0]     add_q
`ifdef ADDER_RR_SCHED_STATS_EN
  ,
  output logic [31:0]        stat_issued,
  output logic [31:0]        stat_stall
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] grant_s;
  logic [ID_W-1:0]    grant_id_s;
  logic               xfer_s;

  logic [WIDTH-1:0]   add_a_q, add_a_d;
  logic [WIDTH-1:0]   add_b_q, add_b_d;

  // Stage k holds the op issued k+1 cycles ago; the last stage lines up with add_q.
  logic [ADD_LATENCY:0] pipe_vld_q, pipe_vld_d;
  logic [ID_W-1:0]      pipe_id_q [ADD_LATENCY+1];
  logic [ID_W-1:0]      pipe_id_d [ADD_LATENCY+1];

  logic               resp_valid_q, resp_valid_d;
  logic [ID_W-1:0]    resp_id_q, resp_id_d;
  logic [WIDTH:0]     resp_q_q, resp_q_d;

`ifdef ADDER_RR_SCHED_STATS_EN
  logic [31:0]        stat_issued_q, stat_issued_d;
  logic [31:0]        stat_stall_q, stat_stall_d;
`endif

  // Round-robin search from rr_ptr: first valid requester wins, gated by en.
  always_comb begin
    logic [ID_W-1:0] idx;
    logic            hit;
    grant_s    = {NUM_REQ{1'b0}};
    grant_id_s = {ID_W{1'b0}};
    xfer_s     = 1'b0;
    idx        = {ID_W{1'b0}};
    hit        = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx          = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      hit          = en & bus.req_valid[idx] & ~xfer_s;
      grant_s[idx] = grant_s[idx] | hit;
      grant_id_s   = hit ? idx : grant_id_s;
      xfer_s       = xfer_s | hit;
    end
  end

  // Next state: capture granted operands, advance pointer and tracking pipe, form response.
  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    add_a_d       = add_a_q;
    add_b_d       = add_b_q;
    pipe_vld_d    = {pipe_vld_q[ADD_LATENCY-1:0], xfer_s};
    pipe_id_d[0]  = grant_id_s;
    for (int k = 1; k <= ADD_LATENCY; k++) begin
      pipe_id_d[k] = pipe_id_q[k-1];
    end
    resp_valid_d  = pipe_vld_q[ADD_LATENCY];
    resp_id_d     = resp_id_q;
    resp_q_d      = resp_q_q;

    if (xfer_s) begin
      add_a_d = bus.req_a[int'(grant_id_s)*WIDTH +: WIDTH];
      add_b_d = bus.req_b[int'(grant_id_s)*WIDTH +: WIDTH];
      if (int'(grant_id_s) == NUM_REQ - 1) begin
        rr_ptr_d = {ID_W{1'b0}};
      end else begin
        rr_ptr_d = grant_id_s + ID_W'(1);
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end

    // The adder output is only meaningful when the tracked op reaches the end.
    if (pipe_vld_q[ADD_LATENCY]) begin
      resp_id_d = pipe_id_q[ADD_LATENCY];
      resp_q_d  = add_q;
    end else begin
      resp_id_d = resp_id_q;
      resp_q_d  = resp_q_q;
    end
  end

`ifdef ADDER_RR_SCHED_STATS_EN
  // Saturating event counters: issued transfers and cycles with demand but no transfer.
  always_comb begin
    stat_issued_d = stat_issued_q;
    stat_stall_d  = stat_stall_q;
    if (xfer_s && (stat_issued_q != 32'hFFFF_FFFF)) begin
      stat_issued_d = stat_issued_q + 32'd1;
    end else begin
      stat_issued_d = stat_issued_q;
    end
    if ((|bus.req_valid) && !xfer_s && (stat_stall_q != 32'hFFFF_FFFF)) begin
      stat_stall_d = stat_stall_q + 32'd1;
    end else begin
      stat_stall_d = stat_stall_q;
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued_q <= 32'd0;
      stat_stall_q  <= 32'd0;
    end else begin
      stat_issued_q <= stat_issued_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_stall  = stat_stall_q;
`endif

  // State registers; reset drops every in-flight op so no response ever appears for it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q     <= {ID_W{1'b0}};
      add_a_q      <= {WIDTH{1'b0}};
      add_b_q      <= {WIDTH{1'b0}};
      pipe_vld_q   <= {(ADD_LATENCY+1){1'b0}};
      for (int k = 0; k <= ADD_LATENCY; k++) begin
        pipe_id_q[k] <= {ID_W{1'b0}};
      end
      resp_valid_q <= 1'b0;
      resp_id_q    <= {ID_W{1'b0}};
      resp_q_q     <= {(WIDTH+1){1'b0}};
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      pipe_vld_q   <= pipe_vld_d;
      for (int k = 0; k <= ADD_LATENCY; k++) begin
        pipe_id_q[k] <= pipe_id_d[k];
      end
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_q_q     <= resp_q_d;
    end
  end

  assign bus.req_ready  = grant_s;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_q     = resp_q_q;
  assign add_a          = add_a_q;
  assign add_b          = add_b_q;

endmodule
